// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction RAM port, redirect request and decode handshake.
// The fetch unit takes the master side.
interface fetch_unit_if;
    logic        imem_en;
    logic [29:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        halted;

    modport master (
        output imem_en, imem_addr, id_valid, id_instr, id_pc, halted,
        input  imem_data, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_en, imem_addr, id_valid, id_instr, id_pc, halted,
        output imem_data, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches from a 1-cycle synchronous RAM, buffers
// words in a small FIFO for decode, and handles epoch-tagged redirects and halt.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [31:0]      pc_q, pc_d;
    logic             epoch_q, epoch_d;
    logic             infl_q, infl_d;
    logic [31:0]      infl_pc_q, infl_pc_d;
    logic             infl_epoch_q, infl_epoch_d;
    logic             halt_pend_q, halt_pend_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic             id_valid_q, id_valid_d;
    logic [31:0]      id_instr_q, id_instr_d;
    logic [31:0]      id_pc_q, id_pc_d;
    logic [31:0]      mem_instr_q [DEPTH];
    logic [31:0]      mem_pc_q    [DEPTH];

    logic             redir_c, pop_c, halt_pop_c, flush_c, push_c, issue_c;
    logic [OCC_W-1:0] occ_c;
    logic [CNT_W-1:0] left_c;
    logic [PTR_W-1:0] rd_pop_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit rule: buffered + in-flight never exceeds DEPTH, counting this cycle's pop.
    assign redir_c    = bus.redirect_valid && !halted_q;
    assign pop_c      = id_valid_q && bus.id_ready;
    assign halt_pop_c = pop_c && (id_instr_q == HALT_WORD);
    assign flush_c    = redir_c || halt_pop_c;
    assign push_c     = infl_q && (infl_epoch_q == epoch_q) && !flush_c;
    assign occ_c      = OCC_W'(cnt_q) + OCC_W'(infl_q);
    assign issue_c    = !rst && !halt_pend_q && !halted_q && !redir_c &&
                        ((occ_c < OCC_W'(DEPTH)) || ((occ_c == OCC_W'(DEPTH)) && pop_c));
    assign left_c     = cnt_q - CNT_W'(pop_c);
    assign rd_pop_c   = pop_c ? ptr_inc(rd_q) : rd_q;

    assign bus.imem_en   = issue_c;
    assign bus.imem_addr = pc_q[31:2];
    assign bus.id_valid  = id_valid_q;
    assign bus.id_instr  = id_instr_q;
    assign bus.id_pc     = id_pc_q;
    assign bus.halted    = halted_q;

    always_comb begin
        pc_d         = pc_q;
        epoch_d      = epoch_q;
        infl_d       = issue_c;
        infl_pc_d    = pc_q;
        infl_epoch_d = epoch_q;
        halt_pend_d  = halt_pend_q;
        halted_d     = halted_q || halt_pop_c;
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;

        if (redir_c) begin
            pc_d        = bus.redirect_pc & ~32'd3;
            epoch_d     = ~epoch_q;
            halt_pend_d = 1'b0;
        end else if (issue_c) begin
            pc_d = pc_q + 32'd4;
        end

        if (flush_c) begin
            cnt_d      = '0;
            rd_d       = '0;
            wr_d       = '0;
            id_valid_d = 1'b0;
        end else begin
            cnt_d      = left_c + CNT_W'(push_c);
            rd_d       = rd_pop_c;
            wr_d       = push_c ? ptr_inc(wr_q) : wr_q;
            id_valid_d = (cnt_d != '0);
            // Head presented next cycle: surviving entry, else the word arriving now.
            if (left_c != '0) begin
                id_instr_d = mem_instr_q[rd_pop_c];
                id_pc_d    = mem_pc_q[rd_pop_c];
            end else if (push_c) begin
                id_instr_d = bus.imem_data;
                id_pc_d    = infl_pc_q;
            end
            if (push_c && (bus.imem_data == HALT_WORD)) begin
                halt_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            epoch_q      <= 1'b0;
            infl_q       <= 1'b0;
            infl_pc_q    <= 32'd0;
            infl_epoch_q <= 1'b0;
            halt_pend_q  <= 1'b0;
            halted_q     <= 1'b0;
            cnt_q        <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= 32'd0;
            id_pc_q      <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            epoch_q      <= epoch_d;
            infl_q       <= infl_d;
            infl_pc_q    <= infl_pc_d;
            infl_epoch_q <= infl_epoch_d;
            halt_pend_q  <= halt_pend_d;
            halted_q     <= halted_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
        end
    end

    // FIFO storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_instr_q[wr_q] <= bus.imem_data;
            mem_pc_q[wr_q]    <= infl_pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle, directed
// scenarios pinned with literal expectations, then a long randomized run.
module tb_fetch_unit;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] HALT     = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .HALT_WORD(HALT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous instruction RAM, 256 words, one-cycle read latency.
    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_data <= ram[bus.imem_addr[7:0]];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: what decode should see, kept as queues.
    logic [31:0] m_pc, m_inf_pc, m_last_instr, m_last_pc;
    logic        m_inf, m_inf_ep, m_ep, m_hp, m_halted;
    logic        m_ok = 1'b0;
    logic [31:0] q_pc[$];
    logic [31:0] q_instr[$];
    logic [31:0] dacc[$];

    always @(negedge clk) begin : model
        logic        e_valid, e_redir, e_pop, e_issue, e_halt_acc, e_push;
        logic [31:0] e_instr, e_pc, word;
        int          occ;
        if (rst) begin
            if (m_ok) chk("imem_en_in_reset", 32'(bus.imem_en), 32'd0);
            m_pc = RESET_PC; m_inf = 1'b0; m_inf_pc = 32'd0; m_inf_ep = 1'b0;
            m_ep = 1'b0; m_hp = 1'b0; m_halted = 1'b0;
            m_last_instr = 32'd0; m_last_pc = 32'd0;
            q_pc.delete(); q_instr.delete();
            m_ok = 1'b1;
        end else if (m_ok) begin
            if (bus.id_valid && bus.id_ready) dacc.push_back(bus.id_pc);
            e_valid = (q_pc.size() != 0);
            e_instr = e_valid ? q_instr[0] : m_last_instr;
            e_pc    = e_valid ? q_pc[0] : m_last_pc;
            e_redir = bus.redirect_valid && !m_halted;
            e_pop   = e_valid && bus.id_ready;
            occ     = q_pc.size() + (m_inf ? 1 : 0);
            e_issue = !m_hp && !m_halted && !e_redir &&
                      ((occ < int'(DEPTH)) || ((occ == int'(DEPTH)) && e_pop));

            chk("imem_en",   32'(bus.imem_en),   32'(e_issue));
            chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc[31:2]));
            chk("id_valid",  32'(bus.id_valid),  32'(e_valid));
            chk("id_instr",  bus.id_instr,       e_instr);
            chk("id_pc",     bus.id_pc,          e_pc);
            chk("halted",    32'(bus.halted),    32'(m_halted));

            if (e_valid) begin m_last_instr = e_instr; m_last_pc = e_pc; end
            e_halt_acc = 1'b0;
            if (e_pop) begin
                e_halt_acc = (q_instr[0] == HALT);
                void'(q_pc.pop_front());
                void'(q_instr.pop_front());
            end
            if (e_halt_acc) begin
                m_halted = 1'b1;
                q_pc.delete(); q_instr.delete();
            end
            e_push = m_inf && (m_inf_ep == m_ep) && !e_redir && !e_halt_acc;
            if (e_redir) begin
                q_pc.delete(); q_instr.delete();
                m_ep = ~m_ep;
                m_pc = bus.redirect_pc & ~32'd3;
                m_hp = 1'b0;
            end
            if (e_push) begin
                word = ram[m_inf_pc[9:2]];
                q_pc.push_back(m_inf_pc);
                q_instr.push_back(word);
                if (word == HALT) m_hp = 1'b1;
            end
            if (q_pc.size() > int'(DEPTH)) begin
                n_err++;
                $display("FAIL fifo_overflow: occupancy %0d exceeds %0d", q_pc.size(), DEPTH);
            end
            m_inf    = e_issue;
            m_inf_pc = m_pc;
            m_inf_ep = m_ep;
            if (e_issue) m_pc = m_pc + 32'd4;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk_acc(input string name, input int idx, input logic [31:0] exp);
        logic [31:0] act;
        act = (idx < dacc.size()) ? dacc[idx] : 32'hxxxx_xxxx;
        chk(name, act, exp);
    endtask

    task automatic load_straight();
        for (int i = 0; i < 256; i++) ram[i] = 32'h2008_0001 + 32'(i);
    endtask

    // Second reset cycle is used to check reset values; release leaves us in cycle C1.
    task automatic do_reset();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("rst_id_valid",  32'(bus.id_valid), 32'd0);
        chk("rst_id_instr",  bus.id_instr,      32'd0);
        chk("rst_id_pc",     bus.id_pc,         32'd0);
        chk("rst_halted",    32'(bus.halted),   32'd0);
        chk("rst_imem_en",   32'(bus.imem_en),  32'd0);
        chk("rst_imem_addr", 32'(bus.imem_addr), 32'(RESET_PC >> 2));
        step();
        rst = 1'b0;
        dacc.delete();
    endtask

    initial begin
        int base;
        rst = 1'b1;
        bus.id_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'd0;
        load_straight();

        // Straight line
        bus.id_ready = 1'b1;
        do_reset();
        wait_neg(1);
        chk("sl_first_en",   32'(bus.imem_en),   32'd1);
        chk("sl_first_addr", 32'(bus.imem_addr), 32'd0);
        wait_neg(1);
        chk("sl_c2_valid", 32'(bus.id_valid), 32'd0);
        wait_neg(1);
        chk("sl_c3_valid", 32'(bus.id_valid), 32'd1);
        chk("sl_c3_pc",    bus.id_pc,         32'h0);
        chk("sl_c3_instr", bus.id_instr,      32'h2008_0001);
        wait_neg(1); chk("sl_c4_pc", bus.id_pc, 32'h4);
        wait_neg(1); chk("sl_c5_pc", bus.id_pc, 32'h8);
        wait_neg(1); chk("sl_c6_pc", bus.id_pc, 32'hC);
        chk("sl_c6_instr", bus.id_instr, 32'h2008_0004);
        step();

        // Backpressure
        bus.id_ready = 1'b0;
        do_reset();
        wait_neg(3);
        chk("bp_valid", 32'(bus.id_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            wait_neg(1);
            chk("bp_hold_instr", bus.id_instr,      32'h2008_0001);
            chk("bp_no_issue",   32'(bus.imem_en),  32'd0);
        end
        step();
        bus.id_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        for (int i = 0; i < 8; i++) chk_acc("bp_stream", i, 32'(i * 4));

        // Redirect while the word at 0x8 is in flight, then a misaligned redirect
        do_reset();
        step(); step(); step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h40;
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("rd_flushed",   32'(bus.id_valid),  32'd0);
        chk("rd_issue",     32'(bus.imem_en),   32'd1);
        chk("rd_issue_adr", 32'(bus.imem_addr), 32'h10);
        for (int i = 0; i < 6; i++) step();
        chk_acc("rd_acc0", 0, 32'h0);
        chk_acc("rd_acc1", 1, 32'h4);
        chk_acc("rd_acc2", 2, 32'h40);
        chk_acc("rd_acc3", 3, 32'h44);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h43;
        step();
        bus.redirect_valid = 1'b0;
        base = dacc.size();
        for (int i = 0; i < 6; i++) step();
        chk_acc("rd_misaligned", base, 32'h40);

        // Halt
        rst = 1'b1;
        ram[2] = HALT;
        do_reset();
        wait_neg(5);
        chk("ht_c5_halted", 32'(bus.halted),  32'd0);
        chk("ht_c5_en",     32'(bus.imem_en), 32'd0);
        wait_neg(1);
        chk("ht_c6_halted", 32'(bus.halted),   32'd1);
        chk("ht_c6_valid",  32'(bus.id_valid), 32'd0);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h40;
        step();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_neg(1);
            chk("ht_stay_halted", 32'(bus.halted),   32'd1);
            chk("ht_no_valid",    32'(bus.id_valid), 32'd0);
            chk("ht_no_issue",    32'(bus.imem_en),  32'd0);
        end
        chk("ht_acc_count", 32'(dacc.size()), 32'd3);
        chk_acc("ht_acc2", 2, 32'h8);
        step();

        // Mid-run reset at cycle 7
        rst = 1'b1;
        ram[2] = 32'h2008_0003;
        do_reset();
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        dacc.delete();
        @(negedge clk);
        chk("mr_valid",  32'(bus.id_valid),  32'd0);
        chk("mr_pc",     bus.id_pc,          32'd0);
        chk("mr_instr",  bus.id_instr,       32'd0);
        chk("mr_en",     32'(bus.imem_en),   32'd1);
        chk("mr_addr",   32'(bus.imem_addr), 32'd0);
        for (int i = 0; i < 8; i++) step();
        chk_acc("mr_acc0", 0, 32'h0);
        chk_acc("mr_acc1", 1, 32'h4);
        chk_acc("mr_acc2", 2, 32'h8);

        // Randomized run with sparse halts, redirects (some near the wrap point) and resets
        rst = 1'b1;
        for (int i = 0; i < 256; i++)
            ram[i] = ($urandom_range(0, 49) == 0) ? HALT : ($urandom() & 32'h7FFF_FFFF);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.id_ready = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) bus.redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else bus.redirect_pc = 32'($urandom_range(0, 1023));
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
